// File: rtl/aes_key_expand_seq_pkg.sv
// Shared AES key-schedule types, mode lookups and GF(2^8) helpers.
package aes_pkg;

   typedef enum logic [1:0] {
      MODE_128     = 2'd0,
      MODE_192     = 2'd1,
      MODE_256     = 2'd2,
      MODE_ILLEGAL = 2'd3
   } aes_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } ks_state_e;

   // Depth of the expanded-key word store for the largest supported key.
   function automatic int unsigned rk_words(input int unsigned max_nk);
      return 4 * (max_nk + 7);
   endfunction

   // Key length in 32-bit words for a mode code.
   function automatic logic [3:0] nk_of(input logic [1:0] mode);
      case (mode)
         MODE_192: return 4'd6;
         MODE_256: return 4'd8;
         default:  return 4'd4;
      endcase
   endfunction

   // Number of cipher rounds for a mode code.
   function automatic logic [3:0] nr_of(input logic [1:0] mode);
      case (mode)
         MODE_192: return 4'd12;
         MODE_256: return 4'd14;
         default:  return 4'd10;
      endcase
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   // Forward S-box: inverse followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_expand_seq_sub_bytes.sv
// Byte-wise AES S-box substitution over N bytes (used as SubWord with N=4).
module sub_bytes
   import aes_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [8*N-1:0] data_i,
   output logic [8*N-1:0] data_o
);

   for (genvar gi = 0; gi < N; gi++) begin : g_sbox
      assign data_o[8*gi +: 8] = sbox(data_i[8*gi +: 8]);
   end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per cycle,
// with a 128-bit round-key read port into the expanded word store.
module aes_key_expand_seq
   import aes_pkg::*;
#(
   parameter int unsigned MAX_NK = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_v_i,
   output logic         key_r_o,
   input  logic [255:0] key_i,
   input  logic [1:0]   mode_i,
   input  logic         abort_i,
   input  logic         rd_v_i,
   input  logic [3:0]   rd_round_i,
   output logic [127:0] rk_o,
   output logic         rk_v_o,
   output logic         sched_v_o,
   output logic         done_o,
   output logic         err_o
);

   localparam int unsigned RK_WORDS = rk_words(MAX_NK);
   localparam int unsigned AW       = $clog2(RK_WORDS);

   ks_state_e      state_q, state_d;
   logic [AW-1:0]  i_q, i_d;
   logic [2:0]     j_q, j_d;
   logic [7:0]     rcon_q, rcon_d;
   logic [3:0]     nk_q, nk_d;
   logic [3:0]     nr_q, nr_d;
   logic           ready_q, ready_d;
   logic           sched_q, sched_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [127:0]   rk_q, rk_d;
   logic           rk_v_q, rk_v_d;

   logic [31:0]    store_q [RK_WORDS];

   logic           key_legal, accept, key_bad, exp_go, last_word;
   logic [AW-1:0]  last_idx, rd_base;
   logic [31:0]    prev_w, old_w, sub_in, sub_out, t_w, new_w;
   logic [31:0]    rd_word [4];

   assign key_legal = (mode_i != MODE_ILLEGAL) && (nk_of(mode_i) <= 4'(MAX_NK));
   assign accept    = key_v_i && ready_q && !abort_i && key_legal;
   assign key_bad   = key_v_i && ready_q && !key_legal;
   assign exp_go    = (state_q == ST_EXPAND) && !abort_i;
   // Final word index 4*(Nr+1)-1 is just Nr with two low ones appended.
   assign last_idx  = AW'({nr_q, 2'b11});
   assign last_word = (i_q == last_idx);

   // Schedule datapath: RotWord is muxed ahead of the single SubWord instance.
   assign prev_w = store_q[i_q - AW'(1)];
   assign old_w  = store_q[i_q - AW'(nk_q)];
   assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   sub_bytes #(.N(4)) u_subword (
      .data_i (sub_in),
      .data_o (sub_out)
   );

   assign t_w   = (j_q == 3'd0)                      ? (sub_out ^ {rcon_q, 24'h0}) :
                  (nk_q == 4'd8 && j_q == 3'd4)      ? sub_out : prev_w;
   assign new_w = old_w ^ t_w;

   // Four consecutive store words form one round key.
   assign rd_base = AW'({rd_round_i, 2'b00});
   for (genvar gi = 0; gi < 4; gi++) begin : g_rd
      assign rd_word[gi] = store_q[rd_base + AW'(gi)];
   end

   // Next-state, schedule counters and pulse outputs.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      rcon_d  = rcon_q;
      nk_d    = nk_q;
      nr_d    = nr_q;
      sched_d = sched_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rk_d    = rk_q;
      rk_v_d  = rd_v_i;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (abort_i) begin
               sched_d = 1'b0;
            end else if (accept) begin
               state_d = ST_EXPAND;
               i_d     = AW'(nk_of(mode_i));
               j_d     = 3'd0;
               rcon_d  = 8'h01;
               nk_d    = nk_of(mode_i);
               nr_d    = nr_of(mode_i);
               sched_d = 1'b0;
            end
            if (key_bad) err_d = 1'b1;
         end
         ST_EXPAND: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else begin
               i_d = i_q + AW'(1);
               j_d = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
               if (j_q == 3'd0) rcon_d = xtime(rcon_q);
               if (last_word) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  sched_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (rd_v_i) begin
         if (rd_round_i > nr_q) begin
            rk_d  = 128'h0;
            err_d = 1'b1;
         end else begin
            rk_d = {rd_word[0], rd_word[1], rd_word[2], rd_word[3]};
         end
      end
   end

   assign ready_d = (state_d != ST_EXPAND);

   // Control and output registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= 3'd0;
         rcon_q  <= 8'h01;
         nk_q    <= 4'd4;
         nr_q    <= 4'd10;
         ready_q <= 1'b0;
         sched_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rk_q    <= 128'h0;
         rk_v_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rcon_q  <= rcon_d;
         nk_q    <= nk_d;
         nr_q    <= nr_d;
         ready_q <= ready_d;
         sched_q <= sched_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rk_q    <= rk_d;
         rk_v_q  <= rk_v_d;
      end
   end

   // Word store: whole-key load on accept, otherwise one schedule word per cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < int'(MAX_NK); k++) begin
            if (k < int'(nk_of(mode_i))) store_q[k] <= key_i[255-32*k -: 32];
         end
      end else if (exp_go) begin
         store_q[i_q] <= new_w;
      end
   end

   assign key_r_o   = ready_q;
   assign rk_o      = rk_q;
   assign rk_v_o    = rk_v_q;
   assign sched_v_o = sched_q;
   assign done_o    = done_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboard bench for the sequential AES key expander using FIPS-197 vectors.
module tb_aes_key_expand_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_v_i;
   logic         key_r_o;
   logic [255:0] key_i;
   logic [1:0]   mode_i;
   logic         abort_i;
   logic         rd_v_i;
   logic [3:0]   rd_round_i;
   logic [127:0] rk_o;
   logic         rk_v_o;
   logic         sched_v_o;
   logic         done_o;
   logic         err_o;

   aes_key_expand_seq #(.MAX_NK(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_v_i    (key_v_i),
      .key_r_o    (key_r_o),
      .key_i      (key_i),
      .mode_i     (mode_i),
      .abort_i    (abort_i),
      .rd_v_i     (rd_v_i),
      .rd_round_i (rd_round_i),
      .rk_o       (rk_o),
      .rk_v_o     (rk_v_o),
      .sched_v_o  (sched_v_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] KEY_A1 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
   localparam logic [255:0] KEY_A2 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
   localparam logic [255:0] KEY_A3 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

   typedef struct {
      logic [3:0]   rnd;
      logic [127:0] rk;
      logic         err;
   } rk_exp_t;

   rk_exp_t exp_rk[$];
   int      exp_done[$];
   int      exp_err;
   int      checks;
   int      errors;
   int      cyc;
   int      accept_cyc;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the expected response whenever the DUT presents one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done_o) begin
            chk("done_expected", 128'(exp_done.size() != 0), 128'd1);
            if (exp_done.size() != 0) begin
               int lat;
               lat = exp_done.pop_front();
               $display("done latency %0d (expected %0d)", cyc - accept_cyc, lat);
               chk("done_latency", 128'(cyc - accept_cyc), 128'(lat));
            end
         end
         if (rk_v_o) begin
            chk("rk_expected", 128'(exp_rk.size() != 0), 128'd1);
            if (exp_rk.size() != 0) begin
               rk_exp_t e;
               e = exp_rk.pop_front();
               $display("read round %0d rk=%h err=%b", e.rnd, rk_o, err_o);
               chk("rk_value", rk_o, e.rk);
               chk("rk_err", 128'(err_o), 128'(e.err));
            end
         end else if (err_o) begin
            $display("err pulse");
            chk("err_expected", 128'(exp_err != 0), 128'd1);
            if (exp_err != 0) exp_err--;
         end
         if (key_v_i && key_r_o && !abort_i && mode_i != 2'd3) accept_cyc = cyc + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_key(input logic [1:0] mode, input logic [255:0] key, input int lat);
      if (lat > 0) exp_done.push_back(lat);
      key_i   = key;
      mode_i  = mode;
      key_v_i = 1'b1;
      tick();
      key_v_i = 1'b0;
   endtask

   task automatic wait_sched(input string name);
      for (int n = 0; n < 100 && !sched_v_o; n++) tick();
      chk(name, 128'(sched_v_o), 128'd1);
      chk({name, "_ready"}, 128'(key_r_o), 128'd1);
   endtask

   task automatic rd(input logic [3:0] rnd, input logic [127:0] rk, input logic err);
      rk_exp_t e;
      e.rnd = rnd;
      e.rk  = rk;
      e.err = err;
      exp_rk.push_back(e);
      rd_round_i = rnd;
      rd_v_i     = 1'b1;
      tick();
      rd_v_i     = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; exp_err = 0; cyc = 0; accept_cyc = 0;
      rst_n = 1'b0; key_v_i = 1'b0; key_i = '0; mode_i = 2'd0;
      abort_i = 1'b0; rd_v_i = 1'b0; rd_round_i = 4'd0;

      // Reset state
      repeat (3) tick();
      chk("reset_key_r", 128'(key_r_o), 128'd0);
      chk("reset_sched", 128'(sched_v_o), 128'd0);
      chk("reset_rk", rk_o, 128'h0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_reset", 128'(key_r_o), 128'd1);

      // FIPS A.1
      start_key(2'd0, KEY_A1, 40);
      chk("a1_busy", 128'(key_r_o), 128'd0);
      wait_sched("a1_sched");
      rd(4'd0,  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b0);
      rd(4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0);
      rd(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b0);
      rd(4'd11, 128'h0, 1'b1);

      // Illegal mode: error pulse, nothing accepted
      exp_err++;
      key_i = KEY_A3; mode_i = 2'd3; key_v_i = 1'b1;
      tick();
      key_v_i = 1'b0;
      tick();
      chk("illegal_ready", 128'(key_r_o), 128'd1);
      chk("illegal_sched_kept", 128'(sched_v_o), 128'd1);

      // FIPS A.3
      start_key(2'd2, KEY_A3, 52);
      wait_sched("a3_sched");
      rd(4'd0,  128'h603deb10_15ca71be_2b73aef0_857d7781, 1'b0);
      rd(4'd1,  128'h1f352c07_3b6108d7_2d9810a3_0914dff4, 1'b0);
      rd(4'd2,  128'h9ba35411_8e6925af_a51a8b5f_2067fcde, 1'b0);
      rd(4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e, 1'b0);

      // Abort an A.3 run at its 20th cycle
      start_key(2'd2, KEY_A3, 0);
      repeat (19) tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_sched", 128'(sched_v_o), 128'd0);
      chk("abort_ready", 128'(key_r_o), 128'd1);
      repeat (60) tick();
      chk("abort_no_sched", 128'(sched_v_o), 128'd0);

      // A.1 after abort
      start_key(2'd0, KEY_A1, 40);
      wait_sched("a1b_sched");
      rd(4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0);
      rd(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b0);

      // Asynchronous reset mid-expansion
      start_key(2'd1, KEY_A2, 0);
      repeat (10) tick();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_key_r", 128'(key_r_o), 128'd0);
      chk("arst_sched", 128'(sched_v_o), 128'd0);
      chk("arst_done", 128'(done_o), 128'd0);
      chk("arst_err", 128'(err_o), 128'd0);
      chk("arst_rk_v", 128'(rk_v_o), 128'd0);
      chk("arst_rk", rk_o, 128'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_ready", 128'(key_r_o), 128'd1);

      // FIPS A.2
      start_key(2'd1, KEY_A2, 46);
      wait_sched("a2_sched");
      rd(4'd0,  128'h8e73b0f7_da0e6452_c810f32b_809079e5, 1'b0);
      rd(4'd1,  128'h62f8ead2_522c6b7b_fe0c91f7_2402f5a5, 1'b0);
      rd(4'd12, 128'he98ba06f_448c773c_8ecc7204_01002202, 1'b0);
      rd(4'd13, 128'h0, 1'b1);

      // key_v_i held high in DONE starts a new run; ignored during EXPAND
      exp_done.push_back(40);
      key_i = KEY_A1; mode_i = 2'd0; key_v_i = 1'b1;
      tick();
      chk("hold_busy", 128'(key_r_o), 128'd0);
      chk("hold_sched_clr", 128'(sched_v_o), 128'd0);
      repeat (5) tick();
      key_v_i = 1'b0;
      wait_sched("hold_sched");
      rd(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b0);

      // Abort in DONE only clears sched_v_o
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("done_abort_sched", 128'(sched_v_o), 128'd0);
      chk("done_abort_ready", 128'(key_r_o), 128'd1);

      repeat (3) tick();
      chk("drain_rk", 128'(exp_rk.size()), 128'd0);
      chk("drain_done", 128'(exp_done.size()), 128'd0);
      chk("drain_err", 128'(exp_err), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
